// File: rtl/key_load_sequencer_if.sv
// Key bus between the key load sequencer (master) and the key expansion core (slave).
interface key_load_sequencer_if #(
  parameter int KEY_W = 256
);
  logic             o_start;
  logic [1:0]       o_key_mode;
  logic [KEY_W-1:0] o_key;
  logic             i_key_ready;

  modport master (output o_start, output o_key_mode, output o_key, input i_key_ready);
  modport slave  (input o_start, input o_key_mode, input o_key, output i_key_ready);
endinterface

// File: rtl/key_load_sequencer.sv
// Multi-slot AES key store and expansion sequencer driving the key expansion core.
// Optional expander wait timeout is enabled by defining KEYSEQ_TIMEOUT_EN.
module key_load_sequencer #(
  parameter int NUM_SLOTS = 4,
  parameter int KEY_W     = 256,
  parameter int TIMEOUT   = 64,
  localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 resetL,
  input  logic                 wr_en,
  input  logic [SLOT_W-1:0]    wr_slot,
  input  logic [1:0]           wr_mode,
  input  logic [KEY_W-1:0]     wr_key,
  input  logic                 act_valid,
  output logic                 act_ready,
  input  logic [SLOT_W-1:0]    act_slot,
  key_load_sequencer_if.master kbus,
  output logic [NUM_SLOTS-1:0] slot_loaded,
  output logic [SLOT_W-1:0]    active_slot,
  output logic                 active_valid,
  output logic                 busy,
  output logic                 err_pulse
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_LOW  = 2'd2;
  localparam logic [1:0] WAIT_HIGH = 2'd3;

  logic [1:0]       state;
  logic [KEY_W-1:0] key_mem  [NUM_SLOTS];
  logic [1:0]       mode_mem [NUM_SLOTS];
  logic [KEY_W-1:0] key_q;
  logic [1:0]       mode_q;

  logic wr_legal, wr_hits_active, wr_hits_act;
  logic act_fire, act_loaded, act_reuse, act_start;
  logic waiting, restart, done, timed_out;

  // A same-cycle legal write counts as loading the slot being activated.
  assign wr_legal       = wr_en && (wr_mode != 2'b11);
  assign wr_hits_active = wr_legal && (wr_slot == active_slot);
  assign wr_hits_act    = wr_legal && (wr_slot == act_slot);
  assign act_fire       = act_valid && (state == IDLE);
  assign act_loaded     = slot_loaded[act_slot] || wr_hits_act;
  assign act_reuse      = (act_slot == active_slot) && active_valid && !wr_hits_active;
  assign act_start      = act_fire && act_loaded && !act_reuse;
  assign waiting        = (state == WAIT_LOW) || (state == WAIT_HIGH);
  assign restart        = waiting && wr_hits_active;
  assign done           = (state == WAIT_HIGH) && kbus.i_key_ready && !restart;

`ifdef KEYSEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL)      wait_cnt <= '0;
    else if (waiting) wait_cnt <= wait_cnt + 1'b1;
    else              wait_cnt <= '0;
  end

  // Completion and restart take priority over an expiring wait.
  assign timed_out = waiting && !restart && !done && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      slot_loaded <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        key_mem[i]  <= '0;
        mode_mem[i] <= '0;
      end
    end else if (wr_legal) begin
      key_mem[wr_slot]     <= wr_key;
      mode_mem[wr_slot]    <= wr_mode;
      slot_loaded[wr_slot] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      state        <= IDLE;
      active_slot  <= '0;
      active_valid <= 1'b0;
      key_q        <= '0;
      mode_q       <= '0;
      err_pulse    <= 1'b0;
    end else begin
      err_pulse <= (wr_en && !wr_legal) || (act_fire && !act_loaded) || timed_out;
      if (wr_hits_active) active_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (act_start) begin
            state        <= START;
            active_slot  <= act_slot;
            active_valid <= 1'b0;
            key_q        <= wr_hits_act ? wr_key  : key_mem[act_slot];
            mode_q       <= wr_hits_act ? wr_mode : mode_mem[act_slot];
          end
        end
        START: state <= WAIT_LOW;
        default: begin
          // A rewrite of the slot being expanded restarts with the fresh key.
          if (restart) begin
            state  <= START;
            key_q  <= wr_key;
            mode_q <= wr_mode;
          end else if (done) begin
            state        <= IDLE;
            active_valid <= 1'b1;
          end else if (timed_out) begin
            state <= IDLE;
          end else if ((state == WAIT_LOW) && !kbus.i_key_ready) begin
            state <= WAIT_HIGH;
          end
        end
      endcase
    end
  end

  assign act_ready       = (state == IDLE);
  assign busy            = (state != IDLE);
  assign kbus.o_start    = (state == START);
  assign kbus.o_key      = key_q;
  assign kbus.o_key_mode = mode_q;

endmodule

// File: tb/tb_key_load_sequencer.sv
// Randomized self-checking bench for key_load_sequencer against a slot/transaction reference model.
module tb_key_load_sequencer;
  localparam int NS = 4;
  localparam int KW = 256;
  localparam int TO = 8;
`ifdef KEYSEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetL;
  logic          wr_en, act_valid, act_ready, active_valid, busy, err_pulse;
  logic [1:0]    wr_slot, act_slot, active_slot, wr_mode;
  logic [KW-1:0] wr_key;
  logic [NS-1:0] slot_loaded;

  key_load_sequencer_if #(.KEY_W(KW)) kbus ();

  key_load_sequencer #(.NUM_SLOTS(NS), .KEY_W(KW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetL(resetL), .wr_en(wr_en), .wr_slot(wr_slot), .wr_mode(wr_mode),
    .wr_key(wr_key), .act_valid(act_valid), .act_ready(act_ready), .act_slot(act_slot),
    .kbus(kbus), .slot_loaded(slot_loaded), .active_slot(active_slot),
    .active_valid(active_valid), .busy(busy), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: slot store plus an expansion job tracked by phase flags.
  bit          m_loaded [NS];
  logic [KW-1:0] m_key  [NS];
  logic [1:0]  m_mode   [NS];
  int          m_active;
  bit          m_valid, m_busy, m_starting, m_seen_low, m_err;
  int          m_wait;
  logic [KW-1:0] m_okey;
  logic [1:0]  m_omode;

  task automatic check_output(input string tag, input logic [KW-1:0] got, input logic [KW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_loaded[i] = 1'b0;
      m_key[i]    = '0;
      m_mode[i]   = '0;
    end
    m_active = 0; m_valid = 0; m_busy = 0; m_starting = 0; m_seen_low = 0;
    m_err = 0; m_wait = 0; m_okey = '0; m_omode = '0;
  endtask

  task automatic model_step();
    bit legal, hit_active, hit_act, err;
    legal      = wr_en && (wr_mode != 2'b11);
    hit_active = legal && (int'(wr_slot) == m_active);
    hit_act    = legal && (wr_slot == act_slot);
    err        = wr_en && !legal;
    if (!m_busy) begin
      if (act_valid) begin
        if (!(m_loaded[act_slot] || hit_act)) err = 1'b1;
        else if (!(int'(act_slot) == m_active && m_valid && !hit_active)) begin
          m_active = int'(act_slot); m_busy = 1; m_starting = 1; m_seen_low = 0;
          m_wait = 0; m_valid = 0;
          m_okey  = hit_act ? wr_key  : m_key[act_slot];
          m_omode = hit_act ? wr_mode : m_mode[act_slot];
        end
      end
      if (hit_active) m_valid = 0;
    end else if (m_starting) begin
      m_starting = 0;
      m_wait     = 0;
    end else if (hit_active) begin
      m_starting = 1; m_seen_low = 0; m_valid = 0;
      m_okey = wr_key; m_omode = wr_mode;
    end else if (m_seen_low && kbus.i_key_ready) begin
      m_busy = 0; m_valid = 1;
    end else if (TO_EN && m_wait == TO - 1) begin
      m_busy = 0; err = 1;
    end else begin
      if (!kbus.i_key_ready) m_seen_low = 1;
      m_wait++;
    end
    if (legal) begin
      m_key[wr_slot] = wr_key; m_mode[wr_slot] = wr_mode; m_loaded[wr_slot] = 1'b1;
    end
    m_err = err;
  endtask

  task automatic check_model();
    logic [NS-1:0] exp_loaded;
    for (int i = 0; i < NS; i++) exp_loaded[i] = m_loaded[i];
    check_output("act_ready",    KW'(act_ready),       KW'(!m_busy));
    check_output("busy",         KW'(busy),            KW'(m_busy));
    check_output("o_start",      KW'(kbus.o_start),    KW'(m_starting));
    check_output("active_valid", KW'(active_valid),    KW'(m_valid));
    check_output("active_slot",  KW'(active_slot),     KW'(m_active));
    check_output("slot_loaded",  KW'(slot_loaded),     KW'(exp_loaded));
    check_output("err_pulse",    KW'(err_pulse),       KW'(m_err));
    check_output("o_key",        kbus.o_key,           m_okey);
    check_output("o_key_mode",   KW'(kbus.o_key_mode), KW'(m_omode));
  endtask

  // One cycle: check current outputs, drive new inputs, advance the model, move to next negedge.
  task automatic apply_stimulus(input bit we, input int ws, input logic [1:0] wm, input logic [KW-1:0] wk,
                                input bit av, input int as, input bit rdy);
    logic [31:0] ws_v, as_v;
    check_model();
    ws_v = ws; as_v = as;
    wr_en = we; wr_slot = ws_v[1:0]; wr_mode = wm; wr_key = wk;
    act_valid = av; act_slot = as_v[1:0]; kbus.i_key_ready = rdy;
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    apply_stimulus(0, 0, 2'b00, '0, 0, 0, rdy);
  endtask

  function automatic logic [KW-1:0] rand_key();
    logic [KW-1:0] k;
    for (int i = 0; i < KW / 32; i++) k[i*32 +: 32] = $urandom;
    return k;
  endfunction

  localparam logic [KW-1:0] KEY_A5 = {32{8'hA5}};
  localparam logic [KW-1:0] KEY_K0 = {8{32'h0123_4567}};
  localparam logic [KW-1:0] KEY_B  = {32{8'h3C}};

  initial begin
    resetL = 1'b0; wr_en = 0; wr_slot = 0; wr_mode = 0; wr_key = '0;
    act_valid = 0; act_slot = 0; kbus.i_key_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetL = 1'b1;
    check_output("rst_act_ready",   KW'(act_ready),    KW'(1));
    check_output("rst_slot_loaded", KW'(slot_loaded),  KW'(0));
    check_output("rst_busy",        KW'(busy),         KW'(0));
    check_output("rst_o_start",     KW'(kbus.o_start), KW'(0));
    check_output("rst_o_key",       kbus.o_key,        KW'(0));

    // Load slot 2 and expand it with ready dropping at +2 and rising at +5.
    apply_stimulus(1, 2, 2'b10, KEY_A5, 0, 0, 1);
    apply_stimulus(0, 0, 2'b00, '0, 1, 2, 1);
    check_output("a5_start_n1", KW'(kbus.o_start), KW'(1));
    check_output("a5_key",      kbus.o_key,        KEY_A5);
    idle(1);
    check_output("a5_start_n2", KW'(kbus.o_start), KW'(0));
    idle(0); idle(0); idle(0); idle(1);
    check_output("a5_valid_n6", KW'(active_valid), KW'(1));
    check_output("a5_slot",     KW'(active_slot),  KW'(2));
    check_output("a5_ready_n6", KW'(act_ready),    KW'(1));

    apply_stimulus(0, 0, 2'b00, '0, 1, 2, 1);
    check_output("reuse_no_start", KW'(kbus.o_start), KW'(0));
    check_output("reuse_ready",    KW'(act_ready),    KW'(1));
    apply_stimulus(0, 0, 2'b00, '0, 1, 3, 1);
    check_output("unloaded_err",   KW'(err_pulse),    KW'(1));
    check_output("unloaded_start", KW'(kbus.o_start), KW'(0));
    apply_stimulus(1, 1, 2'b11, KEY_B, 0, 0, 1);
    check_output("illegal_err",    KW'(err_pulse),    KW'(1));
    check_output("illegal_loaded", KW'(slot_loaded),  KW'(4'b0100));

    // Same-cycle write+activate, then rewrite the slot while waiting for ready high.
    apply_stimulus(1, 0, 2'b00, KEY_K0, 1, 0, 1);
    check_output("same_cycle_key", kbus.o_key, KEY_K0);
    idle(1); idle(0);
    apply_stimulus(1, 0, 2'b01, KEY_B, 0, 0, 0);
    check_output("restart_start", KW'(kbus.o_start),    KW'(1));
    check_output("restart_key",   kbus.o_key,           KEY_B);
    check_output("restart_mode",  KW'(kbus.o_key_mode), KW'(1));
    idle(1); idle(0); idle(1); idle(1);
    check_output("restart_valid", KW'(active_valid), KW'(1));

    // Expander holding ready high: times out or stays busy depending on the build.
    apply_stimulus(0, 0, 2'b00, '0, 1, 2, 1);
    for (int i = 0; i < 20; i++) idle(1);
    check_output("stuck_busy",  KW'(busy),         KW'(!TO_EN));
    check_output("stuck_valid", KW'(active_valid), KW'(0));
    idle(0); idle(1); idle(1);

    for (int i = 0; i < 400; i++)
      apply_stimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3), 2'($urandom_range(0, 3)),
                     rand_key(), $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 1) == 1);

    // Reset asserted while waiting for ready high.
    apply_stimulus(1, 1, 2'b00, KEY_A5, 1, 1, 1);
    idle(1); idle(0);
    #2 resetL = 1'b0;
    #1;
    check_output("arst_busy",   KW'(busy),         KW'(0));
    check_output("arst_ready",  KW'(act_ready),    KW'(1));
    check_output("arst_loaded", KW'(slot_loaded),  KW'(0));
    check_output("arst_valid",  KW'(active_valid), KW'(0));
    check_output("arst_key",    kbus.o_key,        KW'(0));
    model_reset();
    @(negedge clk);
    resetL = 1'b1;
    idle(1); idle(1);
    check_model();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_load_sequencer.md
# key_load_sequencer

Multi-slot AES key loader and expansion sequencer that sits on the master side of the key bus, in front of the key expansion core. It stores up to NUM_SLOTS cipher keys, each with its own key mode. On request it activates a slot: it drives the stored key and mode to the expander, issues the start pulse, and tracks the expander's ready level, with an optional timeout. It provides fast key-context switching without the host re-sending keys.

## Interface
- NUM_SLOTS, 4, number of key slots (≥2); SLOT_W = $clog2(NUM_SLOTS)
- KEY_W, 256, key width in bits
- TIMEOUT, 64, max cycles spent waiting on the expander (≥4)

- clk  input  1  global clock
- resetL  input  1  asynchronous, active-low global reset
- wr_en  input  1  write key into slot this cycle
- wr_slot  input  SLOT_W  target slot
- wr_mode  input  2  2'b00=128, 2'b01=192, 2'b10=256; 2'b11 illegal
- wr_key  input  KEY_W  key value
- act_valid  input  1  activation request
- act_ready  output  1  sequencer can accept activation
- act_slot  input  SLOT_W  slot to activate
- o_start  output  1  start pulse to expander
- o_key_mode  output  2  mode to expander
- o_key  output  KEY_W  key to expander
- i_key_ready  input  1  expander ready level
- slot_loaded  output  NUM_SLOTS  bit per slot holding a legal key
- active_slot  output  SLOT_W  slot last expanded
- active_valid  output  1  expanded key for active_slot is ready
- busy  output  1  expansion in progress
- err_pulse  output  1  one-cycle error: illegal mode, unloaded slot, or timeout

## Operation
- Writes are always accepted. A legal write stores the key and mode and sets slot_loaded[wr_slot]. A write with mode 2'b11 is dropped and raises err_pulse.
- A write to active_slot clears active_valid. If that write lands in WAIT_LOW or WAIT_HIGH, the FSM restarts in START with the new key.
- An activation handshake completes on act_valid && act_ready. act_ready = (state == IDLE).
- An activation of an unloaded slot raises err_pulse. The slot is not started and active state is unchanged.
- An activation of a slot that equals active_slot while active_valid = 1 is acknowledged with no expansion.
- FSM states:
  - IDLE: on an accepted legal activation, latch active_slot, clear active_valid, go to START.
  - START: drive o_start = 1 for one cycle, then go to WAIT_LOW.
  - WAIT_LOW: wait for i_key_ready = 0, then go to WAIT_HIGH.
  - WAIT_HIGH: on i_key_ready = 1, set active_valid and go to IDLE.
- o_key and o_key_mode are driven from the active_slot registers and are held stable from START until the return to IDLE.
- busy = 1 in START, WAIT_LOW and WAIT_HIGH.
- A write and an activation to the same slot in the same cycle: the write takes effect and the expansion uses the new key.

## Timing
- Reset values:
  - all outputs are 0, except act_ready = 1;
  - slot_loaded = 0, active_slot = 0, state = IDLE.
- Asserting resetL low mid-expansion aborts immediately; slot contents are cleared.
- Activation accepted at cycle N → o_start high at N+1 only.
- i_key_ready seen high in WAIT_HIGH at cycle M → active_valid = 1 and act_ready = 1 at M+1.
- err_pulse is registered and asserts the cycle after the causing event.
- Minimum activation-to-valid latency is 4 cycles for an expander that drops ready at N+2 and raises it at N+3.

## Configuration
- KEYSEQ_TIMEOUT_EN defined:
  - A counter runs in WAIT_LOW and WAIT_HIGH and clears on entry to START.
  - Reaching TIMEOUT forces IDLE with active_valid = 0 and raises err_pulse.
- KEYSEQ_TIMEOUT_EN undefined:
  - There is no counter; the FSM waits indefinitely.
  - Timeout never contributes to err_pulse.

## Test plan
- Reset: after resetL is released, act_ready = 1, slot_loaded = 4'b0000, all other outputs 0.
- Write slot 2, mode 2'b10, key = 256'hA5…A5; activate slot 2; model expander drops ready at +2 and raises it at +5 → o_start at +1 only, o_key = A5…A5, active_valid at +6, active_slot = 2.
- Reactivate slot 2 while it is valid → no o_start, act_ready stays 1. Activate unloaded slot 3 → err_pulse, no o_start.
- Write mode 2'b11 to slot 1 → err_pulse, slot_loaded[1] stays 0. Write slot 2 during WAIT_HIGH → FSM returns to START and a second o_start is issued with the new key.
- Timeout with KEYSEQ_TIMEOUT_EN and TIMEOUT = 8, expander holding ready high:
  - err_pulse 8 cycles after entering WAIT_LOW, then IDLE with active_valid = 0.
  - Rebuilt without the macro, the FSM stays busy indefinitely.
- Pull resetL low while in WAIT_HIGH → outputs return to reset values asynchronously and slot_loaded = 0.
